keccak_squeeze_unit: RTL and testbench

Squeeze-side reader of the Keccak sponge state. It takes a permuted 1600-bit state array and streams the rate portion out as 64-bit little-endian lanes over a valid/ready interface. When the rate is exhausted and output bytes remain, it requests another Keccak-f permutation and resumes on the returned state. It sits between the permutation core (theta/rho/pi/chi/iota round logic) and the digest/XOF consumer, opposite the absorb unit that writes the state.

---
 rtl/keccak_pkg.sv | 28 ++
 rtl/keccak_lane_mux.sv | 29 ++
 rtl/keccak_squeeze_unit.sv | 179 +++++++++++++++++
 tb/tb_keccak_squeeze_unit.sv | 284 ++++++++++++++++++++++++++++
 4 files changed

// File: rtl/keccak_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : keccak_pkg
//  Description : Shared Keccak sponge types and constants (state geometry,
//                squeeze-side limits and FSM encoding).
//  Revision    : 1.0 - initial release
// ============================================================================
package keccak_pkg;

    localparam int ROW_SIZE  = 5;
    localparam int COL_SIZE  = 5;
    localparam int LANE_SIZE = 64;

    // Largest rate any supported instance uses (SHAKE128, 1344 bits).
    localparam int SQUEEZE_MAX_RATE_LANES = 21;

    // Sponge state indexed [x][y][z]; lane i of the byte stream is x + 5y.
    typedef logic [ROW_SIZE-1:0][COL_SIZE-1:0][LANE_SIZE-1:0] keccak_state_t;

    typedef enum logic [1:0] {
        SQZ_IDLE      = 2'd0,
        SQZ_EMIT      = 2'd1,
        SQZ_WAIT_PERM = 2'd2,
        SQZ_FINISH    = 2'd3
    } squeeze_fsm_e;

endpackage
`default_nettype wire

// File: rtl/keccak_lane_mux.sv
`default_nettype none
// ============================================================================
//  Module      : keccak_lane_mux
//  Description : Combinational 25:1 lane select from the sponge state using
//                the linear lane index i = x + 5y.
//  Revision    : 1.0 - initial release
// ============================================================================
module keccak_lane_mux
    import keccak_pkg::*;
(
    input  keccak_state_t          i_state,
    input  logic [4:0]             i_lane_idx,
    output logic [LANE_SIZE-1:0]   o_lane
);

    // Indices 25..31 never occur in operation and read as zero.
    always_comb begin
        o_lane = '0;
        for (int y = 0; y < COL_SIZE; y++) begin
            for (int x = 0; x < ROW_SIZE; x++) begin
                if (i_lane_idx == 5'(x + ROW_SIZE * y)) begin
                    o_lane = i_state[x][y];
                end
            end
        end
    end

endmodule
`default_nettype wire

// File: rtl/keccak_squeeze_unit.sv
`default_nettype none
// ============================================================================
//  Module      : keccak_squeeze_unit
//  Description : Squeeze-side reader of the Keccak sponge. Streams the rate
//                part of the state as 64-bit little-endian lanes over a
//                valid/ready port and requests further permutations until
//                the requested byte count is delivered.
//  Revision    : 1.0 - initial release
// ============================================================================
module keccak_squeeze_unit
    import keccak_pkg::*;
#(
    parameter int OUT_LEN_W = 16
) (
    input  logic                                            clk,
    input  logic                                            rst,
    input  logic                                            start,
    input  logic [4:0]                                      rate_lanes,
    input  logic [OUT_LEN_W-1:0]                            out_len,
    input  logic [ROW_SIZE-1:0][COL_SIZE-1:0][LANE_SIZE-1:0] state_in,
    output logic                                            perm_req,
    input  logic                                            perm_done,
    output logic [63:0]                                     dout,
    output logic [7:0]                                      dout_keep,
    output logic                                            dout_last,
    output logic                                            dout_valid,
    input  logic                                            dout_ready,
    output logic                                            busy,
    output logic                                            done,
    output logic                                            err
);

    squeeze_fsm_e           r_fsm;
    squeeze_fsm_e           w_fsm_next;
    keccak_state_t          r_state;
    logic [4:0]             r_lane_idx;
    logic [4:0]             r_rate_lanes;
    logic [OUT_LEN_W-1:0]   r_bytes_left;
    logic                   r_err;

    logic [LANE_SIZE-1:0]   w_lane;
    logic [7:0]             w_keep;
    logic                   w_last_beat;
    logic                   w_rate_end;
    logic                   w_rate_ok;
    logic                   w_emit;
    logic                   w_fire;

    keccak_lane_mux u_lane_mux (
        .i_state    (r_state),
        .i_lane_idx (r_lane_idx),
        .o_lane     (w_lane)
    );

    assign w_rate_ok   = (rate_lanes != 5'd0) &&
                         (rate_lanes <= 5'(SQUEEZE_MAX_RATE_LANES));
    assign w_last_beat = (r_bytes_left <= OUT_LEN_W'(8));
    assign w_rate_end  = (r_lane_idx == (r_rate_lanes - 5'd1));
    assign w_emit      = (r_fsm == SQZ_EMIT);
    assign w_fire      = w_emit && dout_ready;

    // Partial final lane: keep only the low bytes still owed to the consumer.
    always_comb begin
        w_keep = 8'hFF;
        if (r_bytes_left < OUT_LEN_W'(8)) begin
            w_keep = (8'd1 << r_bytes_left[2:0]) - 8'd1;
        end
    end

    // Output beat is decoded from registered state only, so it cannot move
    // while the consumer stalls.
    always_comb begin
        dout = '0;
        for (int b = 0; b < 8; b++) begin
            if (w_emit && w_keep[b]) begin
                dout[8*b +: 8] = w_lane[8*b +: 8];
            end
        end
    end

    assign dout_valid = w_emit;
    assign dout_keep  = w_emit ? w_keep : 8'h00;
    assign dout_last  = w_emit && w_last_beat;
    assign perm_req   = (r_fsm == SQZ_WAIT_PERM);
    assign done       = (r_fsm == SQZ_FINISH);
    assign busy       = (r_fsm != SQZ_IDLE);
    assign err        = r_err;

    // FSM state register.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_fsm <= SQZ_IDLE;
        end else begin
            r_fsm <= w_fsm_next;
        end
    end

    // Next-state decode; the final beat goes straight to FINISH even when it
    // also closes a rate block, so no useless permutation is requested.
    always_comb begin
        w_fsm_next = r_fsm;
        case (r_fsm)
            SQZ_IDLE: begin
                if (start && w_rate_ok) begin
                    w_fsm_next = (out_len == '0) ? SQZ_FINISH : SQZ_EMIT;
                end
            end
            SQZ_EMIT: begin
                if (w_fire) begin
                    if (w_last_beat) begin
                        w_fsm_next = SQZ_FINISH;
                    end else if (w_rate_end) begin
                        w_fsm_next = SQZ_WAIT_PERM;
                    end
                end
            end
            SQZ_WAIT_PERM: begin
                if (perm_done) begin
                    w_fsm_next = SQZ_EMIT;
                end
            end
            SQZ_FINISH: begin
                w_fsm_next = SQZ_IDLE;
            end
            default: begin
                w_fsm_next = SQZ_IDLE;
            end
        endcase
    end

    // Datapath: state capture, lane pointer, remaining byte count, error pulse.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state      <= '0;
            r_lane_idx   <= '0;
            r_rate_lanes <= '0;
            r_bytes_left <= '0;
            r_err        <= 1'b0;
        end else begin
            r_err <= 1'b0;
            case (r_fsm)
                SQZ_IDLE: begin
                    if (start) begin
                        if (!w_rate_ok) begin
                            r_err <= 1'b1;
                        end else begin
                            r_state      <= state_in;
                            r_lane_idx   <= '0;
                            r_rate_lanes <= rate_lanes;
                            r_bytes_left <= out_len;
                        end
                    end
                end
                SQZ_EMIT: begin
                    if (w_fire) begin
                        if (w_last_beat) begin
                            r_bytes_left <= '0;
                        end else begin
                            r_bytes_left <= r_bytes_left - OUT_LEN_W'(8);
                            if (!w_rate_end) begin
                                r_lane_idx <= r_lane_idx + 5'd1;
                            end
                        end
                    end
                end
                SQZ_WAIT_PERM: begin
                    if (perm_done) begin
                        r_state    <= state_in;
                        r_lane_idx <= '0;
                    end
                end
                default: begin
                end
            endcase
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_keccak_squeeze_unit.sv
`default_nettype none
`timescale 1ns/1ps
// ============================================================================
//  Module      : tb_keccak_squeeze_unit
//  Description : Scoreboard bench for keccak_squeeze_unit.
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_keccak_squeeze_unit;
    import keccak_pkg::*;

    typedef struct packed {
        logic [63:0] data;
        logic [7:0]  keep;
        logic        last;
    } beat_t;

    logic          clk = 1'b0;
    logic          rst;
    logic          start;
    logic [4:0]    rate_lanes;
    logic [15:0]   out_len;
    keccak_state_t state_in;
    logic          perm_req;
    logic          perm_done;
    logic [63:0]   dout;
    logic [7:0]    dout_keep;
    logic          dout_last;
    logic          dout_valid;
    logic          dout_ready;
    logic          busy;
    logic          done;
    logic          err;

    int            n_checks   = 0;
    int            n_failures = 0;
    beat_t         exp_q[$];
    keccak_state_t blocks[0:3];

    always #5 clk = ~clk;

    keccak_squeeze_unit #(.OUT_LEN_W(16)) dut (
        .clk        (clk),
        .rst        (rst),
        .start      (start),
        .rate_lanes (rate_lanes),
        .out_len    (out_len),
        .state_in   (state_in),
        .perm_req   (perm_req),
        .perm_done  (perm_done),
        .dout       (dout),
        .dout_keep  (dout_keep),
        .dout_last  (dout_last),
        .dout_valid (dout_valid),
        .dout_ready (dout_ready),
        .busy       (busy),
        .done       (done),
        .err        (err)
    );

    task automatic check_value(input string tag, input logic [72:0] got, input logic [72:0] want);
        n_checks++;
        if (got !== want) begin
            n_failures++;
            $display("FAIL %s got=%h want=%h", tag, got, want);
        end
    endtask

    function automatic keccak_state_t make_state(input int kind);
        keccak_state_t s;
        logic [7:0]    b;
        s = '0;
        for (int i = 0; i < 25; i++) begin
            b = 8'(i);
            case (kind)
                0:       s[i % 5][i / 5] = {8{b}};
                1:       s[i % 5][i / 5] = {8{8'hAA}};
                2:       s[i % 5][i / 5] = {8{8'h55}};
                default: s[i % 5][i / 5] = {$urandom, $urandom};
            endcase
        end
        return s;
    endfunction

    // Reference model: walks the byte stream over the block sequence and
    // returns how many permutations it needs.
    function automatic int push_expected(input int rate, input int len);
        int          bl;
        int          blk;
        int          lane;
        int          n;
        logic [63:0] v;
        beat_t       b;
        bl   = len;
        blk  = 0;
        lane = 0;
        while (bl > 0) begin
            v      = blocks[blk][lane % 5][lane / 5];
            n      = (bl < 8) ? bl : 8;
            b.keep = 8'((16'd1 << n) - 16'd1);
            b.data = '0;
            for (int k = 0; k < n; k++) b.data[8*k +: 8] = v[8*k +: 8];
            b.last = (bl <= 8);
            exp_q.push_back(b);
            bl -= n;
            if (bl > 0) begin
                if (lane == rate - 1) begin
                    blk++;
                    lane = 0;
                end else begin
                    lane++;
                end
            end
        end
        return blk;
    endfunction

    task automatic run_squeeze(input string tag, input int rate, input int len, input bit rand_ready);
        int    exp_perms;
        int    perms;
        int    blk;
        int    cyc;
        int    req_age;
        int    done_cyc;
        int    last_cyc;
        int    first_cyc;
        bit    held;
        beat_t hold_b;
        beat_t cur;
        beat_t want;
        exp_q.delete();
        exp_perms  = push_expected(rate, len);
        start      = 1'b1;
        rate_lanes = 5'(rate);
        out_len    = 16'(len);
        state_in   = blocks[0];
        dout_ready = 1'b1;
        perm_done  = 1'b0;
        @(posedge clk); #1;
        start     = 1'b0;
        perms     = 0;
        blk       = 0;
        req_age   = 0;
        done_cyc  = -1;
        last_cyc  = -1;
        first_cyc = -1;
        held      = 1'b0;
        cyc       = 1;
        while (done_cyc < 0 && cyc < 3000) begin
            perm_done = 1'b0;
            cur = {dout, dout_keep, dout_last};
            if (held) check_value($sformatf("%s/hold", tag), cur, hold_b);
            if (dout_valid && first_cyc < 0) first_cyc = cyc;
            if (done) done_cyc = cyc;
            dout_ready = rand_ready ? ($urandom_range(0, 3) != 0) : 1'b1;
            if (dout_valid && dout_ready) begin
                if (exp_q.size() == 0) begin
                    check_value($sformatf("%s/extra_beat", tag), cur, '0);
                end else begin
                    want = exp_q.pop_front();
                    check_value($sformatf("%s/beat", tag), cur, want);
                end
                if (dout_last) last_cyc = cyc;
                held = 1'b0;
            end else begin
                held   = dout_valid;
                hold_b = cur;
            end
            if (perm_req) begin
                if (req_age == 0) perms++;
                req_age++;
                if (req_age == 3) begin
                    blk++;
                    if (blk <= 3) state_in = blocks[blk];
                    perm_done = 1'b1;
                    req_age   = 0;
                end
            end else begin
                req_age = 0;
            end
            @(posedge clk); #1;
            cyc++;
        end
        perm_done  = 1'b0;
        dout_ready = 1'b1;
        check_value($sformatf("%s/done_seen", tag), done_cyc >= 0, 1);
        if (len == 0) begin
            check_value($sformatf("%s/no_valid", tag), first_cyc, -1);
            check_value($sformatf("%s/done_cyc", tag), done_cyc, 1);
        end else begin
            check_value($sformatf("%s/first_valid_cyc", tag), first_cyc, 1);
            check_value($sformatf("%s/done_after_last", tag), done_cyc, last_cyc + 1);
        end
        check_value($sformatf("%s/perm_reqs", tag), perms, exp_perms);
        check_value($sformatf("%s/beats_left", tag), exp_q.size(), 0);
        check_value($sformatf("%s/busy_low", tag), busy, 1'b0);
    endtask

    task automatic bad_rate(input int rate);
        start      = 1'b1;
        rate_lanes = 5'(rate);
        out_len    = 16'd8;
        @(posedge clk); #1;
        start = 1'b0;
        check_value($sformatf("err_pulse_r%0d", rate), {err, busy, dout_valid}, 3'b100);
        @(posedge clk); #1;
        check_value($sformatf("err_clear_r%0d", rate), {err, busy}, 2'b00);
    endtask

    task automatic reset_in_wait_perm();
        int cyc;
        exp_q.delete();
        start      = 1'b1;
        rate_lanes = 5'd1;
        out_len    = 16'd20;
        state_in   = blocks[0];
        dout_ready = 1'b1;
        @(posedge clk); #1;
        start = 1'b0;
        cyc   = 0;
        while (!perm_req && cyc < 20) begin
            @(posedge clk); #1;
            cyc++;
        end
        check_value("rst/req_before", perm_req, 1'b1);
        #2 rst = 1'b1;
        #1;
        check_value("rst/req_async_drop", {perm_req, busy, dout_valid}, 3'b000);
        @(posedge clk); #1;
        rst = 1'b0;
        @(posedge clk); #1;
        perm_done = 1'b1;
        state_in  = blocks[1];
        @(posedge clk); #1;
        perm_done = 1'b0;
        check_value("rst/perm_done_ignored", {dout_valid, busy, perm_req}, 3'b000);
        @(posedge clk); #1;
        check_value("rst/still_idle", {dout_valid, busy, done}, 3'b000);
    endtask

    initial begin
        rst        = 1'b1;
        start      = 1'b0;
        rate_lanes = '0;
        out_len    = '0;
        state_in   = '0;
        perm_done  = 1'b0;
        dout_ready = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        check_value("reset_outputs",
                    {dout, dout_keep, dout_last, dout_valid, perm_req, busy, done, err}, '0);
        rst = 1'b0;
        @(posedge clk); #1;

        blocks[0] = make_state(0);
        blocks[1] = make_state(1);
        blocks[2] = make_state(2);
        blocks[3] = make_state(3);
        run_squeeze("r17_l32", 17, 32, 1'b0);
        run_squeeze("r21_l13", 21, 13, 1'b0);
        run_squeeze("r1_l20", 1, 20, 1'b0);
        run_squeeze("r2_l16", 2, 16, 1'b0);

        for (int i = 0; i < 4; i++) blocks[i] = make_state(3);
        run_squeeze("shake_bp_l200", 21, 200, 1'b1);
        run_squeeze("len0", 17, 0, 1'b0);

        bad_rate(0);
        bad_rate(22);

        blocks[0] = make_state(0);
        blocks[1] = make_state(1);
        blocks[2] = make_state(2);
        reset_in_wait_perm();
        blocks[0] = make_state(3);
        blocks[1] = make_state(3);
        run_squeeze("after_rst", 17, 150, 1'b1);

        $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_failures);
        $finish;
    end

endmodule
`default_nettype wire
